// File: rtl/fx_pkg.sv
// fx_pkg: shared mode/state encodings for the effect sequencer
package fx_pkg;
    localparam logic [1:0] MODE_UP       = 2'd0;
    localparam logic [1:0] MODE_DOWN     = 2'd1;
    localparam logic [1:0] MODE_PINGPONG = 2'd2;
    localparam logic [1:0] MODE_HOLD     = 2'd3;
    localparam logic [1:0] S_UP          = 2'd0;
    localparam logic [1:0] S_DOWN        = 2'd1;
    localparam logic [1:0] S_BLANK       = 2'd2;
    localparam logic [2:0] STEP_MAX      = 3'd7;
endpackage

// File: rtl/fx_prescaler.sv
// fx_prescaler: programmable-rate tick generator, period 2^(BASE_SHIFT+i_speed) cycles
module fx_prescaler #(
    parameter int BASE_SHIFT = 4,
    parameter int PRESC_W    = BASE_SHIFT + 7
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic [2:0] i_speed,
    output logic       tick_int
);
    logic [PRESC_W-1:0] cnt;
    logic [PRESC_W-1:0] limit;
    assign limit    = (PRESC_W'(1) << (BASE_SHIFT + int'(i_speed))) - PRESC_W'(1);
    assign tick_int = cnt >= limit;
    always_ff @(posedge i_clk) cnt <= (!i_rst_n || tick_int) ? '0 : cnt + PRESC_W'(1);
endmodule

// File: rtl/fx_sequencer.sv
// fx_sequencer: step index engine with pause/manual step and blanked effect switching
module fx_sequencer
    import fx_pkg::*;
#(
    parameter int BASE_SHIFT = 4,
    parameter int PRESC_W    = BASE_SHIFT + 7
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic [2:0] i_speed,
    input  logic [1:0] i_mode,
    input  logic       i_pause,
    input  logic       i_step,
    input  logic [1:0] i_fx_req,
    output logic [2:0] o_count,
    output logic [1:0] o_fx_sel,
    output logic       o_blank,
    output logic       o_tick
);
    logic       tick_int;
    logic       step_prev;
    logic       adv;
    logic       pending;
    logic [1:0] state;
    logic [1:0] next_state;
    logic [2:0] next_count;
    fx_prescaler #(.BASE_SHIFT(BASE_SHIFT), .PRESC_W(PRESC_W)) u_presc (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_speed (i_speed),
        .tick_int(tick_int)
    );
    assign adv     = (tick_int & ~i_pause) | (i_pause & i_step & ~step_prev);
    assign pending = i_fx_req != o_fx_sel;
    always_comb begin
        next_count = i_mode == MODE_UP   ? o_count + 3'd1 :
                     i_mode == MODE_DOWN ? o_count - 3'd1 :
                     i_mode == MODE_HOLD ? o_count :
                     state == S_UP       ? (o_count == STEP_MAX ? STEP_MAX - 3'd1 : o_count + 3'd1) :
                                           (o_count == 3'd0 ? 3'd1 : o_count - 3'd1);
        next_state = i_mode == MODE_UP   ? S_UP :
                     i_mode == MODE_DOWN ? S_DOWN :
                     i_mode == MODE_HOLD ? state :
                     state == S_UP       ? (o_count == STEP_MAX ? S_DOWN : S_UP) :
                                           (o_count == 3'd0 ? S_UP : S_DOWN);
    end
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            o_count   <= '0;
            o_fx_sel  <= '0;
            o_blank   <= 1'b0;
            o_tick    <= 1'b0;
            step_prev <= 1'b0;
            state     <= S_UP;
        end else begin
            step_prev <= i_step;
            o_tick    <= adv;
            if (adv && pending) begin
                o_fx_sel <= i_fx_req;
                o_blank  <= 1'b1;
                o_count  <= '0;
                state    <= S_BLANK;
            end else if (adv && state == S_BLANK) begin
                o_blank <= 1'b0;
                o_count <= i_mode == MODE_DOWN ? STEP_MAX : 3'd0;
                state   <= i_mode == MODE_DOWN ? S_DOWN : S_UP;
            end else if (adv) begin
                o_count <= next_count;
                state   <= next_state;
            end
        end
    end
endmodule

// File: tb/tb_fx_sequencer.sv
// tb_fx_sequencer: scenario tests plus randomized run against a behavioural model
module tb_fx_sequencer;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [2:0] speed = '0;
    logic [1:0] mode = '0;
    logic       pause = 1'b0;
    logic       step = 1'b0;
    logic [1:0] fx_req = '0;
    logic [2:0] count;
    logic [1:0] fx_sel;
    logic       blank;
    logic       tick;
    int total = 0;
    int bad = 0;
    int m_cnt = 0, m_count = 0, m_sel = 0, m_blank = 0, m_tick = 0, m_dir = 0, m_inblank = 0, m_prev = 0;

    always #5 clk = ~clk;

    fx_sequencer #(.BASE_SHIFT(2), .PRESC_W(9)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_speed (speed),
        .i_mode  (mode),
        .i_pause (pause),
        .i_step  (step),
        .i_fx_req(fx_req),
        .o_count (count),
        .o_fx_sel(fx_sel),
        .o_blank (blank),
        .o_tick  (tick)
    );

    task automatic cyc();
        int lim;
        bit t, adv;
        @(posedge clk);
        if (!rst_n) begin
            m_cnt = 0; m_count = 0; m_sel = 0; m_blank = 0; m_tick = 0; m_dir = 0; m_inblank = 0; m_prev = 0;
        end else begin
            lim = (1 << (2 + int'(speed))) - 1;
            t = m_cnt >= lim;
            m_cnt = t ? 0 : m_cnt + 1;
            adv = (t && !pause) || (pause && step && m_prev == 0);
            m_prev = step;
            m_tick = adv;
            if (adv) begin
                if (int'(fx_req) != m_sel) begin
                    m_sel = fx_req; m_blank = 1; m_count = 0; m_inblank = 1;
                end else if (m_inblank) begin
                    m_blank = 0; m_inblank = 0;
                    m_dir = (mode == 1) ? 1 : 0;
                    m_count = (mode == 1) ? 7 : 0;
                end else begin
                    case (mode)
                        0: begin m_count = (m_count + 1) % 8; m_dir = 0; end
                        1: begin m_count = (m_count + 7) % 8; m_dir = 1; end
                        2: begin
                            if (m_dir == 0) begin
                                if (m_count == 7) begin m_count = 6; m_dir = 1; end
                                else m_count = m_count + 1;
                            end else begin
                                if (m_count == 0) begin m_count = 1; m_dir = 0; end
                                else m_count = m_count - 1;
                            end
                        end
                        default: ;
                    endcase
                end
            end
        end
        #1;
    endtask

    task automatic wait_tick(output int n);
        n = 0;
        do begin
            cyc();
            n++;
        end while (tick !== 1'b1 && n < 64);
    endtask

    task automatic go_reset();
        rst_n = 1'b0; fx_req = '0; mode = '0; speed = '0; pause = 1'b0; step = 1'b0;
        repeat (2) cyc();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; fx_req = 2'd2; mode = 2'd2;
        repeat (3) cyc();
        total++; if (count !== 3'd0) begin bad++; $display("FAIL reset_count: got %0d want 0", count); end
        total++; if (fx_sel !== 2'd0) begin bad++; $display("FAIL reset_fx_sel: got %0d want 0", fx_sel); end
        total++; if (blank !== 1'b0) begin bad++; $display("FAIL reset_blank: got %0b want 0", blank); end
        total++; if (tick !== 1'b0) begin bad++; $display("FAIL reset_tick: got %0b want 0", tick); end
    endtask

    task automatic test_up();
        int n;
        go_reset();
        for (int i = 0; i < 3; i++) begin
            cyc();
            total++; if (tick !== 1'b0) begin bad++; $display("FAIL up_early_tick: cycle %0d got %0b want 0", i + 1, tick); end
        end
        cyc();
        total++; if (tick !== 1'b1 || count !== 3'd1) begin bad++; $display("FAIL up_first_tick: tick=%0b count=%0d want tick=1 count=1", tick, count); end
        for (int k = 0; k < 20; k++) begin
            wait_tick(n);
            total++;
            if (n != 4 || count !== 3'((k + 2) % 8)) begin
                bad++; $display("FAIL up_step%0d: gap=%0d count=%0d want gap=4 count=%0d", k, n, count, (k + 2) % 8);
            end
        end
    endtask

    task automatic test_pingpong();
        int n;
        int want[16] = '{1, 2, 3, 4, 5, 6, 7, 6, 5, 4, 3, 2, 1, 0, 1, 2};
        go_reset();
        mode = 2'd2;
        for (int k = 0; k < 16; k++) begin
            wait_tick(n);
            total++;
            if (tick !== 1'b1 || count !== 3'(want[k]) || int'(count) != m_count) begin
                bad++; $display("FAIL pingpong%0d: tick=%0b count=%0d want %0d", k, tick, count, want[k]);
            end
        end
    endtask

    task automatic test_pause();
        int n;
        logic [2:0] base;
        bit moved;
        go_reset();
        wait_tick(n);
        pause = 1'b1;
        base = count;
        moved = 0;
        for (int i = 0; i < 50; i++) begin
            cyc();
            if (tick !== 1'b0 || count !== base) moved = 1;
        end
        total++; if (moved) begin bad++; $display("FAIL pause_frozen: count=%0d tick=%0b want count=%0d tick=0", count, tick, base); end
        for (int p = 0; p < 3; p++) begin
            step = 1'b1;
            cyc();
            total++;
            if (tick !== 1'b1 || count !== base + 3'(p + 1)) begin
                bad++; $display("FAIL pause_step%0d: tick=%0b count=%0d want tick=1 count=%0d", p, tick, count, base + 3'(p + 1));
            end
            repeat (2) cyc();
            total++; if (tick !== 1'b0) begin bad++; $display("FAIL pause_held%0d: tick=%0b want 0", p, tick); end
            step = 1'b0;
            repeat (3) cyc();
        end
        total++; if (count !== base + 3'd3) begin bad++; $display("FAIL pause_total: count=%0d want %0d", count, base + 3'd3); end
        pause = 1'b0;
    endtask

    task automatic test_switch();
        int n;
        go_reset();
        repeat (5) wait_tick(n);
        total++; if (count !== 3'd5) begin bad++; $display("FAIL switch_pre: count=%0d want 5", count); end
        fx_req = 2'd2;
        wait_tick(n);
        total++; if (fx_sel !== 2'd2 || blank !== 1'b1 || count !== 3'd0) begin bad++; $display("FAIL switch_blank: sel=%0d blank=%0b count=%0d want 2 1 0", fx_sel, blank, count); end
        wait_tick(n);
        total++; if (fx_sel !== 2'd2 || blank !== 1'b0 || count !== 3'd0) begin bad++; $display("FAIL switch_exit: sel=%0d blank=%0b count=%0d want 2 0 0", fx_sel, blank, count); end
        mode = 2'd1;
        fx_req = 2'd1;
        wait_tick(n);
        total++; if (fx_sel !== 2'd1 || blank !== 1'b1 || count !== 3'd0) begin bad++; $display("FAIL switch_blank_dn: sel=%0d blank=%0b count=%0d want 1 1 0", fx_sel, blank, count); end
        wait_tick(n);
        total++; if (blank !== 1'b0 || count !== 3'd7) begin bad++; $display("FAIL switch_exit_dn: blank=%0b count=%0d want 0 7", blank, count); end
        wait_tick(n);
        total++; if (count !== 3'd6) begin bad++; $display("FAIL switch_down_step: count=%0d want 6", count); end
    endtask

    task automatic test_speed();
        int n;
        bit early;
        go_reset();
        speed = 3'd7;
        early = 0;
        for (int i = 0; i < 300; i++) begin
            cyc();
            if (tick !== 1'b0) early = 1;
        end
        total++; if (early) begin bad++; $display("FAIL speed_slow: tick seen before 512 cycles, want none"); end
        speed = 3'd0;
        cyc();
        total++; if (tick !== 1'b1) begin bad++; $display("FAIL speed_recover: tick=%0b want 1", tick); end
        wait_tick(n);
        total++; if (n != 4) begin bad++; $display("FAIL speed_period: gap=%0d want 4", n); end
        fx_req = 2'd3;
        wait_tick(n);
        total++; if (blank !== 1'b1 || fx_sel !== 2'd3) begin bad++; $display("FAIL speed_blank: blank=%0b sel=%0d want 1 3", blank, fx_sel); end
        rst_n = 1'b0;
        fx_req = 2'd0;
        cyc();
        total++; if (count !== 3'd0 || fx_sel !== 2'd0 || blank !== 1'b0 || tick !== 1'b0) begin bad++; $display("FAIL blank_reset: count=%0d sel=%0d blank=%0b tick=%0b want all 0", count, fx_sel, blank, tick); end
        rst_n = 1'b1;
        wait_tick(n);
        total++; if (count !== 3'd1 || blank !== 1'b0 || n != 4) begin bad++; $display("FAIL blank_reset_run: count=%0d blank=%0b gap=%0d want 1 0 4", count, blank, n); end
    endtask

    task automatic test_hold();
        int n;
        go_reset();
        mode = 2'd3;
        wait_tick(n);
        total++; if (tick !== 1'b1 || count !== 3'd0) begin bad++; $display("FAIL hold_tick: tick=%0b count=%0d want 1 0", tick, count); end
        fx_req = 2'd1;
        wait_tick(n);
        total++; if (fx_sel !== 2'd1 || blank !== 1'b1 || count !== 3'd0) begin bad++; $display("FAIL hold_switch: sel=%0d blank=%0b count=%0d want 1 1 0", fx_sel, blank, count); end
        wait_tick(n);
        total++; if (blank !== 1'b0 || count !== 3'd0) begin bad++; $display("FAIL hold_exit: blank=%0b count=%0d want 0 0", blank, count); end
        wait_tick(n);
        total++; if (count !== 3'd0 || tick !== 1'b1) begin bad++; $display("FAIL hold_stay: count=%0d tick=%0b want 0 1", count, tick); end
        cyc();
        fx_req = 2'd2;
        cyc();
        fx_req = 2'd1;
        wait_tick(n);
        total++; if (blank !== 1'b0 || fx_sel !== 2'd1) begin bad++; $display("FAIL glitch_req: blank=%0b sel=%0d want 0 1", blank, fx_sel); end
    endtask

    task automatic test_random();
        go_reset();
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 15) == 0) speed = 3'($urandom_range(0, 1));
            if ($urandom_range(0, 9) == 0) mode = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 19) == 0) pause = ~pause;
            if ($urandom_range(0, 2) == 0) step = ~step;
            if ($urandom_range(0, 24) == 0) fx_req = 2'($urandom_range(0, 3));
            rst_n = $urandom_range(0, 299) != 0;
            cyc();
            total++;
            if (int'(count) != m_count || int'(fx_sel) != m_sel || int'(blank) != m_blank || int'(tick) != m_tick) begin
                bad++;
                $display("FAIL random%0d: count=%0d sel=%0d blank=%0b tick=%0b want %0d %0d %0d %0d",
                         i, count, fx_sel, blank, tick, m_count, m_sel, m_blank, m_tick);
            end
        end
    endtask

    initial begin
        test_reset();
        test_up();
        test_pingpong();
        test_pause();
        test_switch();
        test_speed();
        test_hold();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
